alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 16-bit ALU between two requesters (req0: execute stage, req1: address/branch-compare unit).
- Arbitrates per cycle and drives the ALU operands and opcode combinationally from the winner.
- Captures ALU result and zero flag into a one-deep response register, tagged with the winner's ID.
- Sits between the requester pipelines and the combinational ALU; the ALU itself is unchanged.

Parameters:
- DATA_W, 16, operand/result width; must match ALU width.
- CTRL_W, 3, ALU opcode width (0 add, 1 sub, 2 not A, 3 shl, 4 shr, 5 and, 6 or, 7 A>B).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  DATA_W  requester 0 operands.
- req0_ctrl  in  CTRL_W  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl: same as req0, for requester 1.
- alu_a, alu_b  out  DATA_W  operands to the ALU.
- alu_ctrl  out  CTRL_W  opcode to the ALU.
- alu_out  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_ctrl).
- alu_flag  in  1  ALU zero flag.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the result.
- rsp_data  out  DATA_W  registered ALU result.
- rsp_flag  out  1  registered zero flag.

Behaviour:
- Handshake:
  - A transfer occurs when reqN_valid && reqN_ready.
  - A requester holds valid and stable payload until accepted; valid must not depend on ready.
  - reqN_ready may depend combinationally on both valids.
- Slot availability: slot_open = !rsp_valid || rsp_ready. No request is accepted while slot_open = 0.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: round-robin. The winner is the requester not granted last.
  - pointer last_gnt updates only on an actual transfer.
  - Reset value of last_gnt = 1, so req0 wins the first contention.
- Outputs to the requesters: reqN_ready = slot_open && winner==N. At most one ready is high per cycle.
- ALU drive:
  - alu_a/alu_b/alu_ctrl = winner's payload whenever any valid is high, regardless of slot_open.
  - With no valid, all are driven to 0.
- Capture: on a transfer at edge N, rsp_data <= alu_out, rsp_flag <= alu_flag, rsp_id <= winner, rsp_valid <= 1. Latency is 1 cycle: result visible the cycle after acceptance.
- Draining: on rsp_valid && rsp_ready with no new transfer, rsp_valid <= 0. On drain and transfer in the same cycle, the new result replaces the old one; rsp_valid stays 1.
- Stability: rsp_id/rsp_data/rsp_flag hold while rsp_valid && !rsp_ready.
- Reset: synchronous, takes priority over everything. It clears any pending response and any in-flight grant is dropped.
  - rsp_valid=0, rsp_data=0, rsp_flag=0, rsp_id=0, last_gnt=1.
  - Both readys are low during the rst cycle.
- Throughput: 1 operation per cycle when rsp_ready is held high.
- No arithmetic is performed in this block; widths pass through unchanged.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, req0 always beats req1; last_gnt is not implemented. req1 can starve under continuous req0 traffic.
- Undefined: round-robin exactly as in Behaviour.

Test Plan:
- Single request: req0 a=5, b=3, ctrl=0 alone, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0x0008, rsp_flag=0.
- First contention after reset:
  - Stimulus: req0 (a=7, b=7, ctrl=1) and req1 (a=0x00F0, b=4, ctrl=3) both valid.
  - Response: req0 granted first -> rsp 0x0000, flag=1, id=0; following cycle req1 granted -> rsp 0x0F00, flag=0, id=1.
- Fairness: both valid continuously for 6 cycles, rsp_ready=1 -> grants alternate 0,1,0,1,0,1; 6 responses back-to-back.
- Backpressure:
  - Stimulus: response pending with rsp_ready=0 for 3 cycles, both requesters valid.
  - Response: both readys low; rsp_* stable; alu_* show the pending winner.
  - Then rsp_ready=1 -> in the same cycle the old response drains and a new op is accepted; rsp_valid stays 1 with new data.
- Reset mid-operation: assert rst while rsp_valid=1 and both valid -> next cycle rsp_valid=0, rsp_data=0, readys low during rst; first post-reset contention grants req0.
- With ALU_ARB_FIXED_PRIO_EN: both valid continuously for 4 cycles -> all 4 grants to req0, req1_ready stays 0; drop req0_valid -> req1 granted next cycle.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one combinational 16-bit ALU between two requesters and registers the result
// in a one-deep response slot. Define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority.
module alu_arbiter #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_flag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_flag
);

    // Handshake: a request transfers when reqN_valid && reqN_ready; ready depends on both
    // valids and on the response slot, never the other way round. The response side
    // drains on rsp_valid && rsp_ready.
    logic              winner;
    logic              any_valid;
    logic              slot_open;
    logic              xfer;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_flag_q, rsp_flag_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    assign any_valid = req0_valid || req1_valid;
    assign slot_open = !rsp_valid_q || rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = !req0_valid;
    end
`else
    logic last_gnt_q, last_gnt_d;

    // Under contention the requester not granted last wins.
    always_comb begin
        winner = !req0_valid;
        if (req0_valid && req1_valid) begin
            winner = !last_gnt_q;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (xfer) begin
            last_gnt_d = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    assign req0_ready = !rst && slot_open && req0_valid && !winner;
    assign req1_ready = !rst && slot_open && req1_valid && winner;
    assign xfer       = req0_ready || req1_ready;

    // The ALU sees the winner even while the slot is blocked.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (any_valid) begin
            alu_a    = winner ? req1_a    : req0_a;
            alu_b    = winner ? req1_b    : req0_b;
            alu_ctrl = winner ? req1_ctrl : req0_ctrl;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flag_d  = rsp_flag_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = winner;
            rsp_data_d  = alu_out;
            rsp_flag_d  = alu_flag;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flag_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flag_q  <= rsp_flag_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flag  = rsp_flag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, then protocol-respecting random traffic
// checked cycle by cycle against a response-queue model of the arbiter.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_ctrl;
    logic        alu_flag;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_flag;
    logic [15:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the pending response ({id, flag, data}) and who was granted last.
    logic [17:0] exp_q[$];
    int          m_last;
    bit          acc0, acc1;

    typedef struct {
        bit          rst;
        bit          v0;
        logic [15:0] a0, b0;
        logic [2:0]  c0;
        bit          v1;
        logic [15:0] a1, b1;
        logic [2:0]  c1;
        bit          rr;
        bit          e_r0, e_r1, e_v, full, e_id;
        logic [15:0] e_data;
        bit          e_flag;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(logic [15:0] a, logic [15:0] b, logic [2:0] c);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return ~a;
            3'd3: return a << b;
            3'd4: return a >> b;
            3'd5: return a & b;
            3'd6: return a | b;
            default: return (a > b) ? 16'd1 : 16'd0;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_flag = (alu_out == 16'd0);

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flag(rsp_flag)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic row(bit r, bit v0, logic [15:0] a0, logic [15:0] b0, logic [2:0] c0,
                       bit v1, logic [15:0] a1, logic [15:0] b1, logic [2:0] c1, bit rr,
                       bit er0, bit er1, bit ev, bit full, bit eid, logic [15:0] ed, bit ef);
        vec_t v;
        v = '{r, v0, a0, b0, c0, v1, a1, b1, c1, rr, er0, er1, ev, full, eid, ed, ef};
        vecs.push_back(v);
    endtask

    // Model: one pending response at most; winner is whoever is alone, else the one
    // not granted last (or always req0 in fixed-priority builds).
    task automatic model_cycle();
        bit          slot, any, w;
        logic [15:0] ea, eb, res;
        logic [2:0]  ec;
        slot = (exp_q.size() == 0) || rsp_ready;
        any  = req0_valid || req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = (m_last == 0);
`endif
        end else begin
            w = !req0_valid;
        end
        acc0 = !rst && slot && req0_valid && !w;
        acc1 = !rst && slot && req1_valid && w;
        chk("m_req0_ready", 32'(req0_ready), 32'(acc0));
        chk("m_req1_ready", 32'(req1_ready), 32'(acc1));
        ea = any ? (w ? req1_a : req0_a) : 16'd0;
        eb = any ? (w ? req1_b : req0_b) : 16'd0;
        ec = any ? (w ? req1_ctrl : req0_ctrl) : 3'd0;
        chk("m_alu_a", 32'(alu_a), 32'(ea));
        chk("m_alu_b", 32'(alu_b), 32'(eb));
        chk("m_alu_ctrl", 32'(alu_ctrl), 32'(ec));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("m_rsp_fields", 32'({rsp_id, rsp_flag, rsp_data}), 32'(exp_q[0]));
        end
        if (rst) begin
            exp_q.delete();
            m_last = 1;
        end else begin
            if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
            if (acc0 || acc1) begin
                res = alu_fn(ea, eb, ec);
                exp_q.push_back({w, res == 16'd0, res});
                m_last = w ? 1 : 0;
            end
        end
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
        rsp_ready  = 0;
    endtask

    task automatic drive_random();
        if (!(req0_valid && !acc0)) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_a     = 16'($urandom);
            req0_b     = 16'($urandom_range(0, 20));
            req0_ctrl  = 3'($urandom_range(0, 7));
        end
        if (!(req1_valid && !acc1)) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_a     = 16'($urandom);
            req1_b     = 16'($urandom_range(0, 20));
            req1_ctrl  = 3'($urandom_range(0, 7));
        end
        rsp_ready = ($urandom_range(0, 2) != 0);
        rst       = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        row(0, 1, 5, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 0);
        row(0, 1, 7, 7, 1, 1, 16'h00F0, 4, 3, 1, 1, 0, 1, 0, 0, 16'h0008, 0);
        for (int i = 0; i < 3; i++)
            row(0, 1, 7, 7, 1, 1, 16'h00F0, 4, 3, 1, 1, 0, 1, 0, 0, 16'h0000, 1);
        row(0, 0, 0, 0, 0, 1, 16'h00F0, 4, 3, 1, 0, 1, 1, 0, 0, 16'h0000, 1);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h0F00, 0);
        row(1, 1, 7, 7, 1, 1, 16'h00F0, 4, 3, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 16'h0000, 0);
`else
        // single request, drain, reset, first contention, then fairness run
        row(0, 1, 5, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0008, 0);
        row(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
        row(0, 1, 7, 7, 1, 1, 16'h00F0, 4, 3, 1, 1, 0, 0, 1, 0, 16'h0000, 0);
        row(0, 1, 7, 7, 1, 1, 16'h00F0, 4, 3, 1, 0, 1, 1, 0, 0, 16'h0000, 1);
        row(0, 1, 1, 2, 0, 1, 9, 4, 1, 1, 1, 0, 1, 0, 1, 16'h0F00, 0);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) row(0, 1, 1, 2, 0, 1, 9, 4, 1, 1, 0, 1, 1, 0, 0, 16'h0003, 0);
            else            row(0, 1, 1, 2, 0, 1, 9, 4, 1, 1, 1, 0, 1, 0, 1, 16'h0005, 0);
        end
        // backpressure for 3 cycles, then drain and accept together
        for (int i = 0; i < 3; i++)
            row(0, 1, 1, 2, 0, 1, 9, 4, 1, 0, 0, 0, 1, 0, 1, 16'h0005, 0);
        row(0, 1, 1, 2, 0, 1, 9, 4, 1, 1, 1, 0, 1, 0, 1, 16'h0005, 0);
        // reset with a pending response and both valid
        row(1, 1, 1, 2, 0, 1, 9, 4, 1, 0, 0, 0, 1, 0, 0, 16'h0003, 0);
        row(0, 1, 1, 2, 0, 1, 9, 4, 1, 1, 1, 0, 0, 1, 0, 16'h0000, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0003, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0003, 0);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
`endif
        drive_idle();
        rst = 1;
        end_cycle();
        end_cycle();
        exp_q.delete();
        m_last = 1;
        acc0 = 0;
        acc1 = 0;

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_ctrl = vecs[i].c0;
            req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_ctrl = vecs[i].c1;
            rsp_ready = vecs[i].rr;
            #3;
            chk($sformatf("v%0d_req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_r0));
            chk($sformatf("v%0d_req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_r1));
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_v));
            if (vecs[i].e_v || vecs[i].full) begin
                chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].e_id));
                chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_data));
                chk($sformatf("v%0d_rsp_flag", i), 32'(rsp_flag), 32'(vecs[i].e_flag));
            end
            model_cycle();
            end_cycle();
        end

        drive_idle();
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            #3;
            model_cycle();
            end_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
